generic_fifo_fwft_ctrl: RTL

- Single-clock FIFO controller that sequences one external generic two-port memory (DWIDTH x 2^AWIDTH, synchronous write, read address registered on rclk when ren=1, data combinational from the registered address).
- The memory runs with REGISTER_READ=0; its roen and rrst_n are tied off at the parent.
- Owns the write/read pointers, occupancy and flags.
- Adds a 2-entry first-word-fall-through (FWFT) output buffer so the consumer sees head data with rvalid and can pop once per cycle.

---
 rtl/generic_fifo_fwft_ctrl.sv | 132 +++++++++++++
 1 files changed

// File: rtl/generic_fifo_fwft_ctrl.sv
// Single-clock FIFO controller for an external two-port RAM with a 2-entry
// first-word-fall-through output buffer; owns pointers, occupancy and flags.
module generic_fifo_fwft_ctrl #(
    parameter int DWIDTH     = 32,
    parameter int AWIDTH     = 3,
    parameter int AFULL_LVL  = (1 << AWIDTH) - 2,
    parameter int AEMPTY_LVL = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wen,
    input  logic [DWIDTH-1:0] wdata,
    input  logic              ren,
    output logic [DWIDTH-1:0] rdata,
    output logic              rvalid,
    output logic              full,
    output logic              afull,
    output logic              aempty,
    output logic [AWIDTH+1:0] count,
    output logic              overflow,
    output logic              underflow,
    output logic              mem_wen,
    output logic [AWIDTH-1:0] mem_waddr,
    output logic [DWIDTH-1:0] mem_wdata,
    output logic              mem_ren,
    output logic [AWIDTH-1:0] mem_raddr,
    input  logic [DWIDTH-1:0] mem_rdata
);
    localparam int RAM_DEPTH = 1 << AWIDTH;
    localparam logic [AWIDTH:0]   DEPTH_L  = RAM_DEPTH[AWIDTH:0];
    localparam logic [AWIDTH:0]   AFULL_L  = AFULL_LVL[AWIDTH:0];
    localparam logic [AWIDTH+1:0] AEMPTY_L = AEMPTY_LVL[AWIDTH+1:0];

    logic [AWIDTH-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AWIDTH:0]   ram_used_q, ram_used_d;
    logic              fetch_pending_q, fetch_pending_d;
    logic [1:0]        out_cnt_q, out_cnt_d;
    logic [DWIDTH-1:0] buf0_q, buf0_d, buf1_q, buf1_d;
    logic              full_q, full_d, afull_q, afull_d, aempty_q, aempty_d;
    logic [AWIDTH+1:0] count_q, count_d;
    logic              overflow_q, overflow_d, underflow_q, underflow_d;

    logic              push_ok, pop_ok, capture, fetch, has_unfetched;
    logic [2:0]        buf_claim;
    logic [1:0]        slot;

    always_comb begin
        push_ok       = wen & ~full_q;
        pop_ok        = ren & (out_cnt_q != 2'd0);
        capture       = fetch_pending_q;
        has_unfetched = (ram_used_q - (AWIDTH+1)'(fetch_pending_q)) != '0;
        // Entries already owed to the output buffer after this cycle's pop.
        buf_claim     = 3'(out_cnt_q) + 3'(fetch_pending_q) - 3'(pop_ok);
        fetch         = has_unfetched & (buf_claim < 3'd2);

        mem_wen   = push_ok & ~rst;
        mem_waddr = wptr_q;
        mem_wdata = wdata;
        mem_ren   = fetch & ~rst;
        mem_raddr = rptr_q;

        wptr_d          = wptr_q + AWIDTH'(push_ok);
        rptr_d          = rptr_q + AWIDTH'(fetch);
        // RAM slot stays reserved until its read data has been captured.
        ram_used_d      = ram_used_q + (AWIDTH+1)'(push_ok) - (AWIDTH+1)'(capture);
        fetch_pending_d = fetch;
        out_cnt_d       = out_cnt_q + 2'(capture) - 2'(pop_ok);

        buf0_d = buf0_q;
        buf1_d = buf1_q;
        if (pop_ok && out_cnt_q == 2'd2) begin
            buf0_d = buf1_q;
        end
        slot = out_cnt_q - 2'(pop_ok);
        if (capture) begin
            if (slot == 2'd0) begin
                buf0_d = mem_rdata;
            end else begin
                buf1_d = mem_rdata;
            end
        end

        full_d      = (ram_used_d == DEPTH_L);
        afull_d     = (ram_used_d >= AFULL_L);
        count_d     = (AWIDTH+2)'(ram_used_d) + (AWIDTH+2)'(out_cnt_d);
        aempty_d    = (count_d <= AEMPTY_L);
        overflow_d  = wen & full_q;
        underflow_d = ren & (out_cnt_q == 2'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q          <= '0;
            rptr_q          <= '0;
            ram_used_q      <= '0;
            fetch_pending_q <= 1'b0;
            out_cnt_q       <= 2'd0;
            buf0_q          <= '0;
            buf1_q          <= '0;
            full_q          <= 1'b0;
            afull_q         <= 1'b0;
            aempty_q        <= 1'b1;
            count_q         <= '0;
            overflow_q      <= 1'b0;
            underflow_q     <= 1'b0;
        end else begin
            wptr_q          <= wptr_d;
            rptr_q          <= rptr_d;
            ram_used_q      <= ram_used_d;
            fetch_pending_q <= fetch_pending_d;
            out_cnt_q       <= out_cnt_d;
            buf0_q          <= buf0_d;
            buf1_q          <= buf1_d;
            full_q          <= full_d;
            afull_q         <= afull_d;
            aempty_q        <= aempty_d;
            count_q         <= count_d;
            overflow_q      <= overflow_d;
            underflow_q     <= underflow_d;
        end
    end

    assign rdata     = buf0_q;
    assign rvalid    = (out_cnt_q != 2'd0);
    assign full      = full_q;
    assign afull     = afull_q;
    assign aempty    = aempty_q;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule
